// File: rtl/game_screen_banner_if.sv
// Signal bundle between the OLED pixel-index decoder / game logic (master)
// and the text banner renderer (slave).
interface game_screen_banner_if #(
   parameter int TEXT_LEN = 16
) ();
   localparam int AW = $clog2(TEXT_LEN);

   logic          frame_begin;
   logic [6:0]    x;
   logic [5:0]    y;
   logic          text_we;
   logic [AW-1:0] text_addr;
   logic [5:0]    text_char;
   logic [1:0]    mode;
   logic          highlight;
   logic [15:0]   oled_data;

   // No valid/ready: frame_begin and text_we are single-cycle strobes that are
   // always accepted; oled_data answers the x/y presented one clock earlier.
   modport master (
      output frame_begin, x, y, text_we, text_addr, text_char, mode, highlight,
      input  oled_data
   );

   modport slave (
      input  frame_begin, x, y, text_we, text_addr, text_char, mode, highlight,
      output oled_data
   );
endinterface

// File: rtl/game_screen_banner.sv
// Renders a writable text buffer with a 3x5 font into the 96x64 OLED pixel
// stream; static, blinking, scrolling and blink+scroll modes, optional invert.
module game_screen_banner #(
   parameter int          TEXT_LEN      = 16,
   parameter int          ORIGIN_X      = 20,
   parameter int          ORIGIN_Y      = 5,
   parameter logic [15:0] FG            = 16'h0000,
   parameter logic [15:0] BG            = 16'hFFFF,
   parameter int          BLINK_FRAMES  = 30,
   parameter int          SCROLL_FRAMES = 2
) (
   input  logic                clk,
   input  logic                reset,
   game_screen_banner_if.slave bus,
   output logic                dbg_state_o
);
   localparam int AW    = $clog2(TEXT_LEN);
   localparam int WIN_W = 4 * TEXT_LEN;
   localparam int REL_W = AW + 2;

   // 12-bit window bounds so x < ORIGIN_X compares as outside, never wrapped.
   localparam logic [11:0] X_LO = 12'(ORIGIN_X);
   localparam logic [11:0] X_HI = 12'(ORIGIN_X + WIN_W);
   localparam logic [11:0] Y_LO = 12'(ORIGIN_Y);
   localparam logic [11:0] Y_HI = 12'(ORIGIN_Y + 5);

   localparam logic [7:0]       BLINK_LAST  = 8'(BLINK_FRAMES - 1);
   localparam logic [7:0]       SCROLL_LAST = 8'(SCROLL_FRAMES - 1);
   localparam logic [REL_W-1:0] ORG_REL     = REL_W'(ORIGIN_X);
   localparam logic [2:0]       ORG_ROW     = 3'(ORIGIN_Y);

   typedef enum logic {
      WAIT_FRAME = 1'b0,
      RUN        = 1'b1
   } state_e;

   state_e           state_q;
   logic [5:0]       text_q [TEXT_LEN];
   logic [1:0]       active_mode_q;
   logic             active_hl_q;
   logic [7:0]       blink_cnt_q;
   logic             blink_vis_q;
   logic [7:0]       scroll_cnt_q;
   logic [REL_W-1:0] scroll_off_q;
   logic [15:0]      oled_data_q;
   logic [15:0]      oled_data_d;

   logic             in_win;
   logic [11:0]      x_ext;
   logic [11:0]      y_ext;
   logic [REL_W-1:0] rel;
   logic [AW-1:0]    char_idx;
   logic [1:0]       col;
   logic [2:0]       row;
   logic [14:0]      glyph;
   logic [2:0]       row_bits;
   logic             lit;
   logic             fg_on;
   logic             mode_change;

   // Rows packed top to bottom, MSB of each row is the leftmost column.
   function automatic logic [14:0] glyph_rom(input logic [5:0] code);
      logic [14:0] g;
      case (code)
         6'd1:  g = 15'b010_101_111_101_101;
         6'd2:  g = 15'b110_101_110_101_110;
         6'd3:  g = 15'b011_100_100_100_011;
         6'd4:  g = 15'b110_101_101_101_110;
         6'd5:  g = 15'b111_100_110_100_111;
         6'd6:  g = 15'b111_100_110_100_100;
         6'd7:  g = 15'b011_100_101_101_011;
         6'd8:  g = 15'b101_101_111_101_101;
         6'd9:  g = 15'b111_010_010_010_111;
         6'd10: g = 15'b001_001_001_101_010;
         6'd11: g = 15'b101_101_110_101_101;
         6'd12: g = 15'b100_100_100_100_111;
         6'd13: g = 15'b101_111_111_101_101;
         6'd14: g = 15'b110_101_101_101_101;
         6'd15: g = 15'b010_101_101_101_010;
         6'd16: g = 15'b110_101_110_100_100;
         6'd17: g = 15'b010_101_101_110_011;
         6'd18: g = 15'b110_101_110_101_101;
         6'd19: g = 15'b011_100_010_001_110;
         6'd20: g = 15'b111_010_010_010_010;
         6'd21: g = 15'b101_101_101_101_111;
         6'd22: g = 15'b101_101_101_101_010;
         6'd23: g = 15'b101_101_111_111_101;
         6'd24: g = 15'b101_101_010_101_101;
         6'd25: g = 15'b101_101_010_010_010;
         6'd26: g = 15'b111_001_010_100_111;
         6'd27: g = 15'b111_101_101_101_111;
         6'd28: g = 15'b010_110_010_010_111;
         6'd29: g = 15'b110_001_010_100_111;
         6'd30: g = 15'b110_001_010_001_110;
         6'd31: g = 15'b101_101_111_001_001;
         6'd32: g = 15'b111_100_110_001_110;
         6'd33: g = 15'b011_100_111_101_111;
         6'd34: g = 15'b111_001_010_010_010;
         6'd35: g = 15'b111_101_111_101_111;
         6'd36: g = 15'b111_101_111_001_110;
         6'd37: g = 15'b000_000_000_000_010;
         6'd38: g = 15'b100_010_001_010_100;
         default: g = 15'b0;
      endcase
      return g;
   endfunction

   always_comb begin
      x_ext    = 12'(bus.x);
      y_ext    = 12'(bus.y);
      in_win   = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
      // Window width is a power of two, so the modulo is just the low bits.
      rel      = REL_W'(bus.x) - ORG_REL + scroll_off_q;
      char_idx = rel[REL_W-1:2];
      col      = rel[1:0];
      row      = 3'(bus.y) - ORG_ROW;
      glyph    = glyph_rom(text_q[char_idx]);
      row_bits = 3'b000;
      case (row)
         3'd0:    row_bits = glyph[14:12];
         3'd1:    row_bits = glyph[11:9];
         3'd2:    row_bits = glyph[8:6];
         3'd3:    row_bits = glyph[5:3];
         3'd4:    row_bits = glyph[2:0];
         default: row_bits = 3'b000;
      endcase
      lit = 1'b0;
      case (col)
         2'd0:    lit = row_bits[2];
         2'd1:    lit = row_bits[1];
         2'd2:    lit = row_bits[0];
         default: lit = 1'b0;
      endcase
      fg_on = lit && !(active_mode_q[0] && !blink_vis_q);
      if (active_hl_q) begin
         fg_on = !fg_on;
      end
      oled_data_d = BG;
      if (state_q == RUN && in_win) begin
         oled_data_d = fg_on ? FG : BG;
      end
      mode_change = (bus.mode != active_mode_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TEXT_LEN; i++) begin
            text_q[i] <= 6'd0;
         end
      end else if (bus.text_we) begin
         text_q[bus.text_addr] <= bus.text_char;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= WAIT_FRAME;
         active_mode_q <= 2'd0;
         active_hl_q   <= 1'b0;
         blink_cnt_q   <= 8'd0;
         blink_vis_q   <= 1'b1;
         scroll_cnt_q  <= 8'd0;
         scroll_off_q  <= '0;
         oled_data_q   <= BG;
      end else begin
         oled_data_q <= oled_data_d;
         case (state_q)
            WAIT_FRAME: begin
               if (bus.frame_begin) begin
                  state_q       <= RUN;
                  active_mode_q <= bus.mode;
                  active_hl_q   <= bus.highlight;
               end
            end
            RUN: begin
               if (bus.frame_begin) begin
                  active_mode_q <= bus.mode;
                  active_hl_q   <= bus.highlight;
                  if (mode_change) begin
                     blink_cnt_q  <= 8'd0;
                     blink_vis_q  <= 1'b1;
                     scroll_cnt_q <= 8'd0;
                     scroll_off_q <= '0;
                  end else begin
                     if (active_mode_q[0]) begin
                        if (blink_cnt_q == BLINK_LAST) begin
                           blink_cnt_q <= 8'd0;
                           blink_vis_q <= !blink_vis_q;
                        end else begin
                           blink_cnt_q <= blink_cnt_q + 8'd1;
                        end
                     end
                     if (active_mode_q[1]) begin
                        if (scroll_cnt_q == SCROLL_LAST) begin
                           scroll_cnt_q <= 8'd0;
                           scroll_off_q <= scroll_off_q + REL_W'(1);
                        end else begin
                           scroll_cnt_q <= scroll_cnt_q + 8'd1;
                        end
                     end
                  end
               end
            end
            default: state_q <= WAIT_FRAME;
         endcase
      end
   end

   assign bus.oled_data = oled_data_q;
   assign dbg_state_o   = (state_q == RUN);
endmodule

// File: tb/tb_game_screen_banner.sv
// Self-checking bench for game_screen_banner against a frame-count reference model.
module tb_game_screen_banner;
   localparam int          TEXT_LEN = 16;
   localparam int          OX       = 20;
   localparam int          OY       = 5;
   localparam int          BLINK    = 30;
   localparam int          SCROLL   = 2;
   localparam int          WIN      = 4 * TEXT_LEN;
   localparam logic [15:0] FG       = 16'h0000;
   localparam logic [15:0] BG       = 16'hFFFF;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic dbg_state;

   game_screen_banner_if #(.TEXT_LEN(TEXT_LEN)) bus ();

   game_screen_banner #(
      .TEXT_LEN(TEXT_LEN), .ORIGIN_X(OX), .ORIGIN_Y(OY), .FG(FG), .BG(BG),
      .BLINK_FRAMES(BLINK), .SCROLL_FRAMES(SCROLL)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   logic [14:0] font_tab [39] = '{
      15'b000_000_000_000_000, 15'b010_101_111_101_101, 15'b110_101_110_101_110,
      15'b011_100_100_100_011, 15'b110_101_101_101_110, 15'b111_100_110_100_111,
      15'b111_100_110_100_100, 15'b011_100_101_101_011, 15'b101_101_111_101_101,
      15'b111_010_010_010_111, 15'b001_001_001_101_010, 15'b101_101_110_101_101,
      15'b100_100_100_100_111, 15'b101_111_111_101_101, 15'b110_101_101_101_101,
      15'b010_101_101_101_010, 15'b110_101_110_100_100, 15'b010_101_101_110_011,
      15'b110_101_110_101_101, 15'b011_100_010_001_110, 15'b111_010_010_010_010,
      15'b101_101_101_101_111, 15'b101_101_101_101_010, 15'b101_101_111_111_101,
      15'b101_101_010_101_101, 15'b101_101_010_010_010, 15'b111_001_010_100_111,
      15'b111_101_101_101_111, 15'b010_110_010_010_111, 15'b110_001_010_100_111,
      15'b110_001_010_001_110, 15'b101_101_111_001_001, 15'b111_100_110_001_110,
      15'b011_100_111_101_111, 15'b111_001_010_010_010, 15'b111_101_111_101_111,
      15'b111_101_111_001_110, 15'b000_000_000_000_010, 15'b100_010_001_010_100
   };

   // Reference state: frames elapsed since the current mode was latched.
   int m_text [TEXT_LEN];
   bit m_run;
   int m_mode;
   bit m_hl;
   int m_n;

   int n_cmp = 0;
   int n_err = 0;

   function automatic logic [15:0] exp_px(input int px, input int py);
      int rel, code, col, row, off;
      bit lit, hidden, on;
      if (!m_run) return BG;
      if (px < OX || px >= OX + WIN || py < OY || py >= OY + 5) return BG;
      off = (m_mode >= 2) ? (m_n / SCROLL) % WIN : 0;
      rel = (px - OX + off) % WIN;
      code = m_text[rel / 4];
      col = rel % 4;
      row = py - OY;
      lit = 1'b0;
      if (col < 3 && code < 39) lit = font_tab[code][14 - (row * 3 + col)];
      hidden = (m_mode % 2 == 1) && ((m_n / BLINK) % 2 == 1);
      on = lit && !hidden;
      if (m_hl) on = !on;
      return on ? FG : BG;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < TEXT_LEN; i++) m_text[i] = 0;
      m_run = 1'b0;
      m_mode = 0;
      m_hl = 1'b0;
      m_n = 0;
   endtask

   task automatic model_frame();
      if (!m_run) begin
         m_run = 1'b1;
         m_n = 0;
      end else if (int'(bus.mode) != m_mode) begin
         m_n = 0;
      end else begin
         m_n++;
      end
      m_mode = int'(bus.mode);
      m_hl = bus.highlight;
   endtask

   task automatic pulse_frame();
      bus.frame_begin = 1'b1;
      @(negedge clk);
      bus.frame_begin = 1'b0;
      model_frame();
   endtask

   task automatic write_char(input int addr, input int code);
      bus.text_we = 1'b1;
      bus.text_addr = 4'(addr);
      bus.text_char = 6'(code);
      @(negedge clk);
      bus.text_we = 1'b0;
      m_text[addr] = code;
   endtask

   task automatic sample_px(input int px, input int py, output logic [15:0] got);
      bus.x = 7'(px);
      bus.y = 6'(py);
      @(negedge clk);
      got = bus.oled_data;
   endtask

   task automatic test_reset();
      logic [15:0] got, exp;
      int px, py;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
      n_cmp++;
      if (dbg_state !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got %0b expected 0", dbg_state);
      end
      write_char(0, 9);
      for (int i = 0; i < 24; i++) begin
         px = (i == 0) ? 21 : $urandom_range(0, 95);
         py = (i == 0) ? 7 : $urandom_range(0, 63);
         sample_px(px, py, got);
         exp = BG;
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL reset_bg: x=%0d y=%0d got %h expected %h", px, py, got, exp);
         end
      end
   endtask

   task automatic test_static();
      logic [15:0] got, exp;
      int pts [4][2] = '{'{21, 7}, '{20, 7}, '{23, 7}, '{20, 5}};
      logic [15:0] spec_v [4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
      bus.mode = 2'd0;
      bus.highlight = 1'b0;
      write_char(0, 9);
      pulse_frame();
      n_cmp++;
      if (dbg_state !== 1'b1) begin
         n_err++;
         $display("FAIL run_state: got %0b expected 1", dbg_state);
      end
      for (int i = 0; i < 4; i++) begin
         sample_px(pts[i][0], pts[i][1], got);
         exp = spec_v[i];
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL static_I: x=%0d y=%0d got %h expected %h", pts[i][0], pts[i][1], got, exp);
         end
      end
      for (int i = 1; i < TEXT_LEN; i++) write_char(i, $urandom_range(0, 63));
      for (int i = 0; i < 60; i++) begin
         int px, py;
         px = $urandom_range(OX - 2, OX + WIN + 1);
         py = $urandom_range(OY - 1, OY + 5);
         sample_px(px, py, got);
         exp = exp_px(px, py);
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL static_rand: x=%0d y=%0d got %h expected %h", px, py, got, exp);
         end
      end
   endtask

   task automatic test_blink();
      logic [15:0] got, exp;
      bus.mode = 2'd1;
      pulse_frame();
      for (int k = 1; k <= 61; k++) begin
         pulse_frame();
         sample_px(21, 7, got);
         exp = exp_px(21, 7);
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL blink: pulse=%0d got %h expected %h", k, got, exp);
         end
      end
   endtask

   task automatic test_scroll();
      logic [15:0] got, exp;
      bus.mode = 2'd2;
      pulse_frame();
      repeat (2) pulse_frame();
      sample_px(20, 7, got);
      n_cmp++;
      if (got !== 16'h0000) begin
         n_err++;
         $display("FAIL scroll_step: got %h expected 0000", got);
      end
      for (int k = 3; k <= 128; k++) begin
         pulse_frame();
         if (k % 16 == 0) begin
            int px, py;
            px = $urandom_range(OX, OX + WIN - 1);
            py = $urandom_range(OY, OY + 4);
            sample_px(px, py, got);
            exp = exp_px(px, py);
            n_cmp++;
            if (got !== exp) begin
               n_err++;
               $display("FAIL scroll_rand: x=%0d y=%0d got %h expected %h", px, py, got, exp);
            end
         end
      end
      sample_px(21, 7, got);
      n_cmp++;
      if (got !== 16'h0000) begin
         n_err++;
         $display("FAIL scroll_wrap: got %h expected 0000", got);
      end
   endtask

   task automatic test_highlight();
      logic [15:0] got;
      int pts [3][2] = '{'{21, 7}, '{23, 7}, '{10, 30}};
      logic [15:0] spec_v [3] = '{16'hFFFF, 16'h0000, 16'hFFFF};
      bus.mode = 2'd0;
      pulse_frame();
      bus.highlight = 1'b1;
      sample_px(21, 7, got);
      n_cmp++;
      if (got !== 16'h0000) begin
         n_err++;
         $display("FAIL hl_midframe: got %h expected 0000", got);
      end
      pulse_frame();
      for (int i = 0; i < 3; i++) begin
         sample_px(pts[i][0], pts[i][1], got);
         n_cmp++;
         if (got !== spec_v[i]) begin
            n_err++;
            $display("FAIL hl: x=%0d y=%0d got %h expected %h", pts[i][0], pts[i][1], got, spec_v[i]);
         end
      end
      bus.highlight = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] got, exp;
      bus.mode = 2'd0;
      pulse_frame();
      bus.text_we = 1'b1;
      bus.text_addr = 4'd3;
      bus.text_char = 6'd1;
      @(negedge clk);
      bus.text_char = 6'd24;
      @(negedge clk);
      bus.text_we = 1'b0;
      m_text[3] = 24;
      // Write coinciding with a frame strobe: both must land.
      bus.text_we = 1'b1;
      bus.text_addr = 4'd4;
      bus.text_char = 6'd38;
      bus.frame_begin = 1'b1;
      @(negedge clk);
      bus.text_we = 1'b0;
      bus.frame_begin = 1'b0;
      m_text[4] = 38;
      model_frame();
      for (int c = 12; c < 20; c++) begin
         for (int r = 0; r < 5; r++) begin
            sample_px(OX + c, OY + r, got);
            exp = exp_px(OX + c, OY + r);
            n_cmp++;
            if (got !== exp) begin
               n_err++;
               $display("FAIL b2b_write: x=%0d y=%0d got %h expected %h", OX + c, OY + r, got, exp);
            end
         end
      end
   endtask

   task automatic test_random_modes();
      logic [15:0] got, exp;
      int px, py;
      bus.mode = 2'd3;
      for (int i = 0; i < TEXT_LEN; i++) write_char(i, $urandom_range(0, 63));
      pulse_frame();
      for (int f = 0; f < 220; f++) begin
         if ($urandom_range(0, 9) == 0) bus.mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) bus.highlight = ~bus.highlight;
         if ($urandom_range(0, 3) == 0) write_char($urandom_range(0, TEXT_LEN - 1), $urandom_range(0, 40));
         pulse_frame();
         for (int s = 0; s < 4; s++) begin
            px = $urandom_range(0, 95);
            py = ($urandom_range(0, 1) == 1) ? $urandom_range(OY - 1, OY + 5) : $urandom_range(0, 63);
            sample_px(px, py, got);
            exp = exp_px(px, py);
            n_cmp++;
            if (got !== exp) begin
               n_err++;
               $display("FAIL rand_mode: mode=%0d n=%0d x=%0d y=%0d got %h expected %h", m_mode, m_n, px, py, got, exp);
            end
         end
      end
      bus.highlight = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [15:0] got;
      bus.mode = 2'd2;
      write_char(0, 9);
      pulse_frame();
      repeat (34) pulse_frame();
      bus.x = 7'd21;
      bus.y = 6'd7;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.oled_data !== BG) begin
         n_err++;
         $display("FAIL reset_async: got %h expected %h", bus.oled_data, BG);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      bus.mode = 2'd0;
      pulse_frame();
      sample_px(21, 7, got);
      n_cmp++;
      if (got !== BG) begin
         n_err++;
         $display("FAIL reset_text: got %h expected %h", got, BG);
      end
      write_char(0, 9);
      sample_px(21, 7, got);
      n_cmp++;
      if (got !== FG) begin
         n_err++;
         $display("FAIL reset_scroll: x=21 got %h expected %h", got, FG);
      end
      sample_px(20, 5, got);
      n_cmp++;
      if (got !== FG) begin
         n_err++;
         $display("FAIL reset_scroll: x=20 got %h expected %h", got, FG);
      end
   endtask

   initial begin
      bus.frame_begin = 1'b0;
      bus.x = 7'd0;
      bus.y = 6'd0;
      bus.text_we = 1'b0;
      bus.text_addr = 4'd0;
      bus.text_char = 6'd0;
      bus.mode = 2'd0;
      bus.highlight = 1'b0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_static();
      test_blink();
      test_scroll();
      test_highlight();
      test_back_to_back();
      test_random_modes();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/game_screen_banner.md
Name: game_screen_banner

Overview:
- Parametrised, clocked successor to the fixed-text game screens.
- Renders a writable TEXT_LEN-character string from a 3x5 glyph ROM onto the 96x64 OLED pixel stream.
- Supports static, blinking, scrolling and blink+scroll modes, plus a highlight (colour-invert) option.
- Sits between the OLED driver's pixel-index decoder (x, y, frame_begin) and its pixel data input; game-state logic writes text and selects the mode.

Parameters:
- TEXT_LEN, 16: characters in the text buffer; power of two, 2..32.
- ORIGIN_X, 20: left column of the text window.
- ORIGIN_Y, 5: top row of the text window.
- FG, 16'h0000: glyph colour.
- BG, 16'hFFFF: background colour.
- BLINK_FRAMES, 30: frames per blink half-period; range 1..255.
- SCROLL_FRAMES, 2: frames per 1-pixel scroll step; range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- frame_begin  in  1  one-cycle pulse at the start of each OLED frame.
- x  in  7  pixel column, 0..95.
- y  in  6  pixel row, 0..63.
- text_we  in  1  text buffer write strobe.
- text_addr  in  $clog2(TEXT_LEN)  character slot to write.
- text_char  in  6  character code: 0 space, 1-26 A-Z, 27-36 0-9, 37 '.', 38 '>'; codes 39-63 render blank.
- mode  in  2  0 STATIC, 1 BLINK, 2 SCROLL, 3 BLINK+SCROLL.
- highlight  in  1  swap FG/BG inside the text window.
- oled_data  out  16  pixel colour.

Behaviour:
- Window:
  - Columns ORIGIN_X .. ORIGIN_X+4*TEXT_LEN-1.
  - Rows ORIGIN_Y .. ORIGIN_Y+4.
  - Every pixel outside the window is BG, in all modes and regardless of highlight.
- Pixel mapping:
  - rel = (x - ORIGIN_X + scroll_off) mod (4*TEXT_LEN).
  - char = rel[.. :2]; col = rel[1:0]; row = y - ORIGIN_Y.
  - col 3 is always the blank spacing column.
  - Glyph bit set -> FG, else BG.
- Latency: oled_data is registered, 1 clk after x/y. No combinational path from x/y to oled_data.
- Text buffer:
  - TEXT_LEN x 6-bit, written synchronously on text_we.
  - A write is visible on the first pixel evaluated in the cycle after the write edge.
  - All slots reset to 0 (space).
- Shadow control:
  - mode and highlight are sampled only on frame_begin into active_mode / active_hl.
  - Mid-frame changes never tear a frame.
- FSM states:
  - WAIT_FRAME:
    - Entered on reset.
    - oled_data forced to BG.
    - Leaves to RUN on the first frame_begin, latching mode/highlight.
  - RUN:
    - Renders per active_mode.
    - Stays in RUN until reset.
- Counters (advance only on frame_begin in RUN):
  - blink_cnt:
    - Counts 0..BLINK_FRAMES-1.
    - On wrap, toggles blink_vis (reset 1).
    - In BLINK modes, blink_vis=0 renders the whole window as BG; highlight still applies, so a highlighted hidden window is FG.
  - scroll_cnt / scroll_off:
    - scroll_cnt counts 0..SCROLL_FRAMES-1.
    - On wrap, scroll_off increments by 1.
    - scroll_off wraps 4*TEXT_LEN-1 -> 0.
    - Held at its current value in non-scroll modes.
- Mode change: when a latched mode differs from the previous active_mode, blink_cnt, scroll_cnt and scroll_off clear to 0 and blink_vis sets to 1 on that same frame_begin.
- Simultaneous events:
  - text_we together with frame_begin: both take effect.
  - text_we to the same slot on consecutive cycles: last write wins.
- Arithmetic: all window comparisons are done unsigned, with an extra bit to avoid wrap. x < ORIGIN_X is outside the window, not wrapped.
- Reset at any time (including mid-scroll or mid-frame):
  - Returns to WAIT_FRAME; oled_data = BG.
  - Counters 0, blink_vis 1, active_mode 0, active_hl 0.
  - Text buffer cleared to spaces.
- Glyph ROM: 39 entries x 5 rows x 3 bits; codes 39-63 render blank. Entry for 'I' (code 9) is rows 111, 010, 010, 010, 111.

Test Plan:
- Reset then no frame_begin -> oled_data = 16'hFFFF for every (x, y), including (21, 7).
- Write code 9 to slot 0, mode=0, pulse frame_begin -> one cycle after (x, y) = (21, 7): 16'h0000; (20, 7): 16'hFFFF; (23, 7): 16'hFFFF (spacing column); (20, 5): 16'h0000.
- mode=1 latched -> pixel (21, 7):
  - 16'h0000 through frame_begin pulses 1-29 after latching.
  - 16'hFFFF after pulses 30-59.
  - 16'h0000 again after pulse 60.
- mode=2 with slot 0 = 'I' -> after 2 frame_begins (scroll_off = 1), (20, 7) shows 16'h0000; after 128 frame_begins (scroll_off wrapped to 0), (21, 7) shows 16'h0000 again.
- highlight=1 asserted mid-frame -> no change until next frame_begin; then (21, 7) = 16'hFFFF, (23, 7) = 16'h0000, (10, 30) = 16'hFFFF.
- Assert reset mid-scroll (scroll_off = 17) -> oled_data = 16'hFFFF immediately; after release plus one frame_begin with mode=0, slot 0 is space and scroll_off = 0.
